// File: rtl/ysyx_23060061_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060061_sram_arbiter_pkg
// Description : Shared encodings for the IFU/LSU SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060061_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic c_OWN_IFU = 1'b0;
    localparam logic c_OWN_LSU = 1'b1;
    localparam int   c_CNT_W   = 4;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060061_Reg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060061_Reg
// Description : Enabled register with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060061_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060061_sram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060061_rr_arb2
// Description : Two-way round-robin grant; bit 0 = IFU, bit 1 = LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060061_rr_arb2
    import ysyx_23060061_sram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic r_last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_last_grant == c_OWN_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_OWN_IFU;
        end else if (accept) begin
            r_last_grant <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060061_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060061_sram_arbiter
// Description : Shares one fixed-latency SRAM port between the IFU and LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060061_sram_arbiter
    import ysyx_23060061_sram_arbiter_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_en,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           w_grant;
    logic                 w_idle;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_resp;
    logic                 w_resp_take;

    logic                 r_owner;
    logic [AW-1:0]        r_addr;
    logic                 r_wen;
    logic [DW-1:0]        r_wdata;
    logic [DW/8-1:0]      r_wmask;
    logic [DW-1:0]        r_rdata;

    logic [AW-1:0]        w_addr_d;
    logic                 w_wen_d;
    logic [DW-1:0]        w_wdata_d;
    logic [DW/8-1:0]      w_wmask_d;
    logic [DW-1:0]        w_rdata_d;

    // Every output is forced low while rst is asserted, not just after the edge.
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_accept = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);

    ysyx_23060061_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({lsu_req_valid, ifu_req_valid}),
        .accept (w_accept),
        .grant  (w_grant)
    );

    assign ifu_req_ready = w_idle && w_grant[0];
    assign lsu_req_ready = w_idle && w_grant[1];

    // IFU fetches never write, so their write fields are zeroed when latched.
    assign w_addr_d  = w_grant[1] ? lsu_addr  : ifu_addr;
    assign w_wen_d   = w_grant[1] && lsu_wen;
    assign w_wdata_d = w_grant[1] ? lsu_wdata : '0;
    assign w_wmask_d = w_grant[1] ? lsu_wmask : '0;

    ysyx_23060061_Reg #(.WIDTH(1))    u_owner (.clk(clk), .rst(rst), .din(w_grant[1]), .dout(r_owner), .wen(w_accept));
    ysyx_23060061_Reg #(.WIDTH(AW))   u_addr  (.clk(clk), .rst(rst), .din(w_addr_d),   .dout(r_addr),  .wen(w_accept));
    ysyx_23060061_Reg #(.WIDTH(1))    u_wen   (.clk(clk), .rst(rst), .din(w_wen_d),    .dout(r_wen),   .wen(w_accept));
    ysyx_23060061_Reg #(.WIDTH(DW))   u_wdata (.clk(clk), .rst(rst), .din(w_wdata_d),  .dout(r_wdata), .wen(w_accept));
    ysyx_23060061_Reg #(.WIDTH(DW/8)) u_wmask (.clk(clk), .rst(rst), .din(w_wmask_d),  .dout(r_wmask), .wen(w_accept));

    assign w_capture = (r_state == WAIT) && (r_cnt == '0);
    assign w_rdata_d = r_wen ? '0 : mem_rdata;

    ysyx_23060061_Reg #(.WIDTH(DW))   u_rdata (.clk(clk), .rst(rst), .din(w_rdata_d),  .dout(r_rdata), .wen(w_capture));

    assign w_resp_take = (r_owner == c_OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ISSUE) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = ISSUE;
            ISSUE:                    w_state_nxt = WAIT;
            WAIT:    if (w_capture)   w_state_nxt = RESP;
            RESP:    if (w_resp_take) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    assign w_resp         = (r_state == RESP) && !rst;
    assign ifu_resp_valid = w_resp && (r_owner == c_OWN_IFU);
    assign lsu_resp_valid = w_resp && (r_owner == c_OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? r_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? r_rdata : '0;

    assign mem_en    = (r_state == ISSUE) && !rst;
    assign mem_wen   = mem_en && r_wen;
    assign mem_addr  = rst ? '0 : r_addr;
    assign mem_wdata = rst ? '0 : r_wdata;
    assign mem_wmask = rst ? '0 : r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060061_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060061_sram_arbiter
// Description : Directed vector bench for the SRAM arbiter (LATENCY 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060061_sram_arbiter;

    typedef struct {
        logic        ifu_v;
        logic [31:0] ifu_addr;
        logic        lsu_v;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_wmask;
        logic        exp_own;
        logic [31:0] exp_rdata;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    logic rst, rst4;
    always #5 clk = ~clk;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_en, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic        d4_ifu_req_valid, d4_ifu_req_ready, d4_ifu_resp_valid, d4_ifu_resp_ready;
    logic [31:0] d4_ifu_addr, d4_ifu_rdata;
    logic        d4_lsu_req_ready, d4_lsu_resp_valid;
    logic [31:0] d4_lsu_rdata;
    logic        d4_mem_en, d4_mem_wen;
    logic [31:0] d4_mem_addr, d4_mem_wdata, d4_mem_rdata;
    logic [3:0]  d4_mem_wmask;

    ysyx_23060061_sram_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    ysyx_23060061_sram_arbiter #(.LATENCY(4), .AW(32), .DW(32)) dut4 (
        .clk(clk), .rst(rst4),
        .ifu_req_valid(d4_ifu_req_valid), .ifu_req_ready(d4_ifu_req_ready), .ifu_addr(d4_ifu_addr),
        .ifu_resp_valid(d4_ifu_resp_valid), .ifu_resp_ready(d4_ifu_resp_ready), .ifu_rdata(d4_ifu_rdata),
        .lsu_req_valid(1'b0), .lsu_req_ready(d4_lsu_req_ready), .lsu_addr(32'h0),
        .lsu_wen(1'b0), .lsu_wdata(32'h0), .lsu_wmask(4'h0),
        .lsu_resp_valid(d4_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(d4_lsu_rdata),
        .mem_en(d4_mem_en), .mem_wen(d4_mem_wen), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
        .mem_wmask(d4_mem_wmask), .mem_rdata(d4_mem_rdata)
    );

    // SRAM model: data is only valid in the single cycle LATENCY after mem_en.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'h1357_9BDF);
    endfunction

    logic [15:0] m1_v, m4_v;
    logic [31:0] m1_a [16];
    logic [31:0] m4_a [16];
    always @(posedge clk) begin
        m1_v    <= rst  ? 16'h0 : {m1_v[14:0], mem_en};
        m4_v    <= rst4 ? 16'h0 : {m4_v[14:0], d4_mem_en};
        m1_a[0] <= mem_addr;
        m4_a[0] <= d4_mem_addr;
        for (int i = 1; i < 16; i++) begin
            m1_a[i] <= m1_a[i-1];
            m4_a[i] <= m4_a[i-1];
        end
    end
    assign mem_rdata    = m1_v[0] ? mem_val(m1_a[0]) : 32'hBAD0_BAD0;
    assign d4_mem_rdata = m4_v[3] ? mem_val(m4_a[3]) : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int n;
        logic [31:0] exp_addr;
        exp_addr = v.exp_own ? v.lsu_addr : v.ifu_addr;
        @(negedge clk);
        ifu_req_valid = v.ifu_v;  ifu_addr  = v.ifu_addr;
        lsu_req_valid = v.lsu_v;  lsu_addr  = v.lsu_addr;  lsu_wen = v.lsu_wen;
        lsu_wdata     = v.lsu_wdata; lsu_wmask = v.lsu_wmask;
        #1;
        n = 0;
        while (!((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check($sformatf("row%0d grant", idx), {30'h0, lsu_req_ready, ifu_req_ready}, v.exp_own ? 32'h2 : 32'h1);
        check($sformatf("row%0d accept_wait", idx), n, 0);
        @(negedge clk);
        if (v.exp_own) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        #1;
        check($sformatf("row%0d issue mem_en", idx), mem_en, 1);
        check($sformatf("row%0d issue mem_addr", idx), mem_addr, exp_addr);
        check($sformatf("row%0d issue mem_wen", idx), mem_wen, v.exp_own & v.lsu_wen);
        check($sformatf("row%0d issue mem_wmask", idx), mem_wmask, v.exp_own ? v.lsu_wmask : 4'h0);
        if (v.exp_own) check($sformatf("row%0d issue mem_wdata", idx), mem_wdata, v.lsu_wdata);
        check($sformatf("row%0d busy req_ready", idx), {lsu_req_ready, ifu_req_ready}, 0);
        @(negedge clk); #1;
        check($sformatf("row%0d wait mem_en", idx), mem_en, 0);
        check($sformatf("row%0d wait resp_valid", idx), {lsu_resp_valid, ifu_resp_valid}, 0);
        @(negedge clk); #1;
        check($sformatf("row%0d resp_valid", idx), {30'h0, lsu_resp_valid, ifu_resp_valid}, v.exp_own ? 32'h2 : 32'h1);
        check($sformatf("row%0d rdata", idx), v.exp_own ? lsu_rdata : ifu_rdata, v.exp_rdata);
    endtask

    // Single IFU fetch on the LATENCY=4 instance: mem_en at +1, response at +6.
    task automatic run_d4(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int en_at, en_cnt, resp_at;
        logic [31:0] got;
        en_at = 0; en_cnt = 0; resp_at = 0; got = 32'hX;
        @(negedge clk);
        d4_ifu_req_valid = 1'b1; d4_ifu_addr = addr; d4_ifu_resp_ready = 1'b1;
        #1;
        check({tag, " accept"}, d4_ifu_req_ready, 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) d4_ifu_req_valid = 1'b0;
            #1;
            if (d4_mem_en) begin
                en_cnt++;
                if (en_at == 0) en_at = k;
            end
            if (d4_ifu_resp_valid && resp_at == 0) begin
                resp_at = k;
                got = d4_ifu_rdata;
            end
        end
        check({tag, " mem_en cycle"}, en_at, 1);
        check({tag, " mem_en count"}, en_cnt, 1);
        check({tag, " resp cycle"}, resp_at, 6);
        check({tag, " rdata"}, got, exp);
    endtask

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, bad_resp, bad_en;
        logic [31:0] exp_r;

        vecs[0] = '{1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b0, 32'h0,         4'h0, 1'b1, 32'h9357_8BDF};
        vecs[1] = '{1'b1, 32'h8000_0004, 1'b1, 32'h8000_3000, 1'b0, 32'h0,         4'h0, 1'b0, 32'h9357_9BDB};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h8000_3000, 1'b0, 32'h0,         4'h0, 1'b1, 32'h9357_ABDF};
        vecs[3] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b0, 32'h0,         4'h0, 1'b0, 32'h0010_0073};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 32'h8000_2004, 1'b1, 32'h1234_5678, 4'h3, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h8000_0008, 1'b0, 32'h0,         1'b0, 32'h0,         4'h0, 1'b0, 32'h9357_9BD7};

        rst = 1'b1; rst4 = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF; lsu_resp_ready = 1'b1;
        d4_ifu_req_valid = 1'b0; d4_ifu_addr = 32'h0; d4_ifu_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset req_ready", {ifu_req_ready, lsu_req_ready}, 0);
        check("reset resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("reset mem_en/wen", {mem_en, mem_wen}, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset mem_wmask", mem_wmask, 0);
        check("reset rdata", ifu_rdata | lsu_rdata, 0);
        check("reset d4 outputs", {d4_ifu_req_ready, d4_ifu_resp_valid, d4_mem_en, d4_lsu_resp_valid}, 0);

        @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;

        for (int i = 0; i < 7; i++) run_row(i, vecs[i]);

        // IFU response held off for 5 cycles while the LSU waits to be served.
        @(negedge clk);
        ifu_resp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        #1;
        check("bp ifu accept", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1004; lsu_wen = 1'b0; lsu_wmask = 4'h0;
        #1;
        n = 0;
        while (!ifu_resp_valid && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("bp resp arrives", n, 2);
        exp_r = 32'h9357_9BCF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check($sformatf("bp hold%0d valid", i), ifu_resp_valid, 1);
            check($sformatf("bp hold%0d rdata", i), ifu_rdata, exp_r);
            check($sformatf("bp hold%0d req_ready", i), {ifu_req_ready, lsu_req_ready}, 0);
            check($sformatf("bp hold%0d mem_en", i), mem_en, 0);
        end
        @(negedge clk);
        ifu_resp_ready = 1'b1;
        #1;
        check("bp release valid", ifu_resp_valid, 1);
        @(negedge clk); #1;
        check("bp lsu granted next", {30'h0, lsu_req_ready, ifu_resp_valid}, 32'h2);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        n = 0;
        while (!lsu_resp_valid && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("bp lsu rdata", lsu_rdata, 32'h9357_8BDB);

        run_d4("lat4 first", 32'h8000_0020, 32'h9357_9BFF);

        // Reset lands while the LATENCY=4 instance is in WAIT.
        @(negedge clk);
        d4_ifu_req_valid = 1'b1; d4_ifu_addr = 32'h8000_0024;
        #1;
        check("rstwait accept", d4_ifu_req_ready, 1);
        @(negedge clk);
        d4_ifu_req_valid = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("rstwait outputs", {d4_ifu_req_ready, d4_ifu_resp_valid, d4_lsu_req_ready,
                                  d4_lsu_resp_valid, d4_mem_en, d4_mem_wen}, 0);
        check("rstwait mem_addr", d4_mem_addr, 0);
        check("rstwait rdata", d4_ifu_rdata | d4_lsu_rdata, 0);
        bad_resp = 0; bad_en = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (d4_ifu_resp_valid || d4_lsu_resp_valid) bad_resp++;
            if (d4_mem_en) bad_en++;
        end
        check("rstwait no response", bad_resp, 0);
        check("rstwait no mem_en", bad_en, 0);
        run_d4("lat4 after reset", 32'h8000_0028, 32'h9357_9BF7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
